// File: rtl/cpu_mem_pkg.sv
// Shared types and defaults for the CPU / main-memory interconnect.
// Owner and FSM encodings are used by the arbiter, its picker and neighbouring blocks.
package cpu_mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: bit 0 is the fetch port, bit 1 the data port.
// On contention the port that did not win last time is chosen.
module rr_arb2
    import cpu_mem_pkg::*;
(
    input  logic [1:0] req,
    input  owner_e     last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = (last == OWN_D) ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port synchronous memory between instruction fetch and load/store.
// One transaction in flight; reads return registered data RD_LAT+1 cycles after grant.
module mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    if (RD_LAT < 1) begin : g_rd_lat_check
        $error("mem_arbiter: RD_LAT must be at least 1");
    end

    localparam int CNT_W = $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);

    state_e            state_q, state_d;
    owner_e            last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
    logic              if_rvalid_q, d_rvalid_q;
    logic              capture;
    logic [1:0]        arb_gnt;

    rr_arb2 u_rr_arb2 (
        .req  ({d_req, if_req}),
        .last (last_q),
        .gnt  (arb_gnt)
    );

    // req/gnt handshake: a requester holds req and its command stable until gnt.
    // gnt=1 means the command is presented to memory in that same cycle; dropping
    // req before gnt withdraws it with no side effect. No grants while a read waits.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        capture   = 1'b0;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (!rst && arb_gnt != 2'b00) begin
                    mem_en = 1'b1;
                    if (arb_gnt[1]) begin
                        d_gnt     = 1'b1;
                        mem_we    = d_we;
                        mem_addr  = d_addr;
                        mem_wdata = d_wdata;
                        last_d    = OWN_D;
                    end else begin
                        if_gnt    = 1'b1;
                        mem_addr  = if_addr;
                        mem_wdata = '0;
                        last_d    = OWN_IF;
                    end
                    if (!(arb_gnt[1] && d_we)) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // last_q doubles as the owner of the outstanding read while in WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_q      <= OWN_D;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            if_rvalid_q <= capture && (last_q == OWN_IF);
            d_rvalid_q  <= capture && (last_q == OWN_D);
            if (mem_en) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
            end
            if (capture) begin
                if (last_q == OWN_IF) begin
                    if_rdata_q <= mem_rdata;
                end else begin
                    d_rdata_q <= mem_rdata;
                end
            end
        end
    end

    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = (state_q == ST_WAIT);

endmodule
